dmem_axil_bridge: RTL and testbench



---
 rtl/dmem_axil_bridge.sv | 188 ++++++++++++++++++
 tb/tb_dmem_axil_bridge.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_axil_bridge.sv
// rtl/dmem_axil_bridge.sv - CPU data-memory port to AXI4-Lite master bridge
// One AXI-Lite transaction per CPU request, with a one-cycle ready pulse on completion.
module dmem_axil_bridge #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = 32'h0000_0000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [31:0]       cpu_wdata_i,
    input  logic [3:0]        cpu_byte_sel_i,
    input  logic              cpu_rd_i,
    input  logic              cpu_wr_i,
    output logic [31:0]       cpu_rdata_o,
    output logic              cpu_ready_o,
    output logic [ADDR_W-1:0] m_awaddr_o,
    output logic              m_awvalid_o,
    input  logic              m_awready_i,
    output logic [31:0]       m_wdata_o,
    output logic [3:0]        m_wstrb_o,
    output logic              m_wvalid_o,
    input  logic              m_wready_i,
    input  logic [1:0]        m_bresp_i,
    input  logic              m_bvalid_i,
    output logic              m_bready_o,
    output logic [ADDR_W-1:0] m_araddr_o,
    output logic              m_arvalid_o,
    input  logic              m_arready_i,
    input  logic [31:0]       m_rdata_i,
    input  logic [1:0]        m_rresp_i,
    input  logic              m_rvalid_i,
    output logic              m_rready_o,
    output logic              err_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_RD_D,
        S_WR,
        S_WR_B,
        S_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:2]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [3:0]          strb_q, strb_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic [31:0]         rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                cpu_ready;
    logic                busy;

    // Byte-lane selection happens on the CPU side; the bus only sees word addresses.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            strb_q    <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            strb_q    <= strb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        cnt_d     = cnt_q;
        cpu_ready = 1'b0;
        busy      = 1'b0;

        case (state_q)
            S_IDLE: begin
                cpu_ready = ~(cpu_rd_i | cpu_wr_i);
                if (cpu_wr_i) begin
                    addr_d    = cpu_addr_i[ADDR_W-1:2];
                    wdata_d   = cpu_wdata_i;
                    strb_d    = cpu_byte_sel_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_WR;
                end else if (cpu_rd_i) begin
                    addr_d    = cpu_addr_i[ADDR_W-1:2];
                    arvalid_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = S_RD_A;
                end
            end
            S_RD_A: begin
                busy = 1'b1;
                if (m_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RD_D;
                end
            end
            S_RD_D: begin
                busy = 1'b1;
                if (m_rvalid_i) begin
                    rdata_d = m_rdata_i;
                    if (m_rresp_i != 2'b00) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WR: begin
                busy = 1'b1;
                if (m_awready_i) awvalid_d = 1'b0;
                if (m_wready_i)  wvalid_d  = 1'b0;
                // A channel whose valid is already low has completed its handshake earlier.
                if ((!awvalid_q || m_awready_i) && (!wvalid_q || m_wready_i)) state_d = S_WR_B;
            end
            S_WR_B: begin
                busy = 1'b1;
                if (m_bvalid_i) begin
                    if (m_bresp_i != 2'b00) err_d = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                cpu_ready = 1'b1;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The edge that would bring the counter to TIMEOUT_CYCLES aborts the transaction.
        if (busy) begin
            cnt_d = cnt_q + 1'b1;
            if (TO_EN && (cnt_q == TO_LAST)) begin
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                arvalid_d = 1'b0;
                err_d     = 1'b1;
                rdata_d   = ERR_DATA;
                state_d   = S_DONE;
            end
        end
    end

    assign cpu_ready_o = cpu_ready;
    assign cpu_rdata_o = rdata_q;
    assign err_o       = err_q;
    assign m_awaddr_o  = {addr_q, 2'b00};
    assign m_araddr_o  = {addr_q, 2'b00};
    assign m_awvalid_o = awvalid_q;
    assign m_wvalid_o  = wvalid_q;
    assign m_wdata_o   = wdata_q;
    assign m_wstrb_o   = strb_q;
    assign m_arvalid_o = arvalid_q;
    assign m_rready_o  = (state_q == S_RD_D);
    assign m_bready_o  = (state_q == S_WR_B);

endmodule

// File: tb/tb_dmem_axil_bridge.sv
// tb/tb_dmem_axil_bridge.sv - self-checking bench for dmem_axil_bridge
module tb_dmem_axil_bridge;

    localparam logic [31:0] ERR_D = 32'hDEAD_0BAD;
    localparam int TO_CYC = 8;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic [3:0]  cpu_byte_sel_i;
    logic        cpu_rd_i, cpu_wr_i, cpu_ready_o;
    logic [31:0] m_awaddr_o, m_wdata_o, m_araddr_o, m_rdata_i;
    logic [3:0]  m_wstrb_o;
    logic        m_awvalid_o, m_awready_i, m_wvalid_o, m_wready_i;
    logic [1:0]  m_bresp_i, m_rresp_i;
    logic        m_bvalid_i, m_bready_o, m_arvalid_o, m_arready_i;
    logic        m_rvalid_i, m_rready_o, err_o;

    always #5 clk_i = ~clk_i;

    dmem_axil_bridge #(
        .ADDR_W(32), .TIMEOUT_CYCLES(TO_CYC), .ERR_DATA(ERR_D)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_byte_sel_i(cpu_byte_sel_i),
        .cpu_rd_i(cpu_rd_i), .cpu_wr_i(cpu_wr_i), .cpu_rdata_o(cpu_rdata_o), .cpu_ready_o(cpu_ready_o),
        .m_awaddr_o(m_awaddr_o), .m_awvalid_o(m_awvalid_o), .m_awready_i(m_awready_i),
        .m_wdata_o(m_wdata_o), .m_wstrb_o(m_wstrb_o), .m_wvalid_o(m_wvalid_o), .m_wready_i(m_wready_i),
        .m_bresp_i(m_bresp_i), .m_bvalid_i(m_bvalid_i), .m_bready_o(m_bready_o),
        .m_araddr_o(m_araddr_o), .m_arvalid_o(m_arvalid_o), .m_arready_i(m_arready_i),
        .m_rdata_i(m_rdata_i), .m_rresp_i(m_rresp_i), .m_rvalid_i(m_rvalid_i), .m_rready_o(m_rready_o),
        .err_o(err_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // For reads d_a/d_r are the AR and R slave delays; for writes d_a/d_w/d_r are AW, W and B delays.
    typedef struct {
        bit          wr;
        bit          rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          d_a;
        int          d_w;
        int          d_r;
        logic [31:0] rdata;
        logic [1:0]  resp;
        int          exp_lat;
        logic [31:0] exp_ax;
        logic [31:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(input bit wr, input bit rd, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] sel,
                                input int d_a, input int d_w, input int d_r,
                                input logic [31:0] rdata, input logic [1:0] resp,
                                input int lat, input logic [31:0] ax,
                                input logic [31:0] exp_rdata, input bit exp_err);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.sel = sel;
        v.d_a = d_a; v.d_w = d_w; v.d_r = d_r; v.rdata = rdata; v.resp = resp;
        v.exp_lat = lat; v.exp_ax = ax; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic slave_idle();
        m_arready_i = 1'b0; m_awready_i = 1'b0; m_wready_i = 1'b0;
        m_rvalid_i  = 1'b0; m_bvalid_i  = 1'b0;
        m_rresp_i   = 2'b00; m_bresp_i  = 2'b00;
    endtask

    // Drives one CPU request and plays a delayed AXI-Lite slave until the ready pulse.
    task automatic run_txn(input vec_t v, output int lat, output logic [31:0] ax,
                           output logic [31:0] wd, output logic [3:0] st,
                           output logic [31:0] rd_out, output logic err_out, output int shape_bad);
        int a_cnt = 0, w_cnt = 0, r_cnt = 0;
        bit a_done = 0, w_done = 0, phase2 = 0;
        int m;
        logic [5:0] exp_bus, act_bus;
        lat = -1; ax = '0; wd = '0; st = '0; rd_out = '0; err_out = 1'b0; shape_bad = 0;
        m = (v.d_a > v.d_w) ? v.d_a : v.d_w;
        @(negedge clk_i);
        cpu_rd_i = v.rd; cpu_wr_i = v.wr; cpu_addr_i = v.addr;
        cpu_wdata_i = v.wdata; cpu_byte_sel_i = v.sel;
        #1;
        if (cpu_ready_o !== 1'b0) shape_bad++;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk_i);
            if (k <= v.exp_lat) begin
                if (k == v.exp_lat) exp_bus = 6'b100000;
                else if (v.wr) exp_bus = {1'b0, 1'b0, (k <= 1 + v.d_a), (k <= 1 + v.d_w), 1'b0, (k >= 2 + m)};
                else exp_bus = {1'b0, (k <= 1 + v.d_a), 1'b0, 1'b0, (k >= 2 + v.d_a), 1'b0};
                act_bus = {cpu_ready_o, m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o};
                if (act_bus !== exp_bus) shape_bad++;
            end
            if (cpu_ready_o === 1'b1) begin
                lat = k; rd_out = cpu_rdata_o; err_out = err_o;
                cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
                slave_idle();
            end else begin
                slave_idle();
                if (v.wr) begin
                    if (m_awvalid_o && !a_done) begin
                        if (a_cnt == v.d_a) begin m_awready_i = 1'b1; a_done = 1; ax = m_awaddr_o; end
                        else a_cnt++;
                    end
                    if (m_wvalid_o && !w_done) begin
                        if (w_cnt == v.d_w) begin m_wready_i = 1'b1; w_done = 1; wd = m_wdata_o; st = m_wstrb_o; end
                        else w_cnt++;
                    end
                    if (phase2) begin
                        if (r_cnt == v.d_r) begin m_bvalid_i = 1'b1; m_bresp_i = v.resp; end
                        else r_cnt++;
                    end
                    phase2 = a_done && w_done;
                end else begin
                    if (m_arvalid_o && !a_done) begin
                        if (a_cnt == v.d_a) begin m_arready_i = 1'b1; a_done = 1; ax = m_araddr_o; end
                        else a_cnt++;
                    end
                    if (phase2) begin
                        if (r_cnt == v.d_r) begin m_rvalid_i = 1'b1; m_rresp_i = v.resp; m_rdata_i = v.rdata; end
                        else r_cnt++;
                    end
                    phase2 = a_done;
                end
            end
        end
        cpu_rd_i = 1'b0; cpu_wr_i = 1'b0;
        slave_idle();
    endtask

    task automatic check_txn(input string tag, input vec_t v);
        int lat, shape_bad;
        logic [31:0] ax, wd, rd_out;
        logic [3:0] st;
        logic err_out;
        run_txn(v, lat, ax, wd, st, rd_out, err_out, shape_bad);
        chk({tag, " latency"}, lat, v.exp_lat);
        chk({tag, " bus_addr"}, ax, v.exp_ax);
        chk({tag, " rdata"}, rd_out, v.exp_rdata);
        chk({tag, " err"}, {31'b0, err_out}, {31'b0, v.exp_err});
        chk({tag, " handshake_shape"}, shape_bad, 0);
        if (v.wr) begin
            chk({tag, " wdata"}, wd, v.wdata);
            chk({tag, " wstrb"}, {28'b0, st}, {28'b0, v.sel});
        end
    endtask

    vec_t tbl[6];

    initial begin
        int lat, n_ar;
        logic [31:0] rd_out;
        logic err_out, ar_at_done;
        logic [31:0] model_rdata;
        bit model_err;
        vec_t v;

        tbl[0] = mk(0, 1, 32'h0000_1006, 32'h0, 4'h0,       0, 0, 0, 32'hCAFE_BABE, 2'b00, 3, 32'h0000_1004, 32'hCAFE_BABE, 0);
        tbl[1] = mk(1, 0, 32'h0000_0020, 32'h0000_AB00, 4'b0010, 1, 3, 1, 32'h0, 2'b00, 7, 32'h0000_0020, 32'hCAFE_BABE, 0);
        tbl[2] = mk(1, 1, 32'h0000_0033, 32'h1234_5678, 4'hF, 0, 0, 0, 32'h5555_5555, 2'b00, 3, 32'h0000_0030, 32'hCAFE_BABE, 0);
        tbl[3] = mk(0, 1, 32'h0000_0044, 32'h0, 4'h0,       2, 0, 1, 32'hDEAD_BEEF, 2'b10, 6, 32'h0000_0044, 32'hDEAD_BEEF, 1);
        tbl[4] = mk(1, 0, 32'h0000_0048, 32'hA5A5_0000, 4'b1100, 0, 2, 0, 32'h0, 2'b00, 5, 32'h0000_0048, 32'hDEAD_BEEF, 1);
        tbl[5] = mk(0, 1, 32'h0000_004C, 32'h0, 4'h0,       1, 0, 2, 32'h1111_2222, 2'b00, 6, 32'h0000_004C, 32'h1111_2222, 1);

        rst_i = 1'b0;
        cpu_rd_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = '0; cpu_wdata_i = '0; cpu_byte_sel_i = '0;
        m_rdata_i = '0;
        slave_idle();
        repeat (3) @(negedge clk_i);
        chk("reset bus_valids", {26'b0, m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o, err_o}, 32'h0);
        chk("reset rdata", cpu_rdata_o, 32'h0);
        chk("reset regs", m_awaddr_o | m_wdata_o | {28'b0, m_wstrb_o}, 32'h0);
        rst_i = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("idle ready_no_valids", {26'b0, cpu_ready_o, m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}, 32'h20);
        end

        for (int i = 0; i < 6; i++) check_txn($sformatf("vec%0d", i), tbl[i]);

        // Reset in the middle of a write with a stalled slave.
        @(negedge clk_i);
        cpu_wr_i = 1'b1; cpu_addr_i = 32'h90; cpu_wdata_i = 32'h7777_8888; cpu_byte_sel_i = 4'hF;
        repeat (3) @(negedge clk_i);
        chk("midwr busy", {30'b0, m_awvalid_o, m_wvalid_o}, 32'h3);
        #2 rst_i = 1'b0;
        #1;
        chk("midwr async_valids", {27'b0, m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}, 32'h0);
        chk("midwr async_regs", m_awaddr_o | m_wdata_o | {28'b0, m_wstrb_o}, 32'h0);
        chk("midwr async_err_rdata", cpu_rdata_o | {31'b0, err_o}, 32'h0);
        cpu_wr_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("midwr idle_after", {26'b0, cpu_ready_o, m_arvalid_o, m_awvalid_o, m_wvalid_o, m_rready_o, m_bready_o}, 32'h20);

        // Timeout: the slave never accepts AR.
        cpu_rd_i = 1'b1; cpu_addr_i = 32'h80;
        lat = -1; n_ar = 0; rd_out = '0; err_out = 1'b0; ar_at_done = 1'b1;
        for (int k = 1; k <= 30 && lat < 0; k++) begin
            @(negedge clk_i);
            if (m_arvalid_o === 1'b1) n_ar++;
            if (cpu_ready_o === 1'b1) begin
                lat = k; rd_out = cpu_rdata_o; err_out = err_o; ar_at_done = m_arvalid_o;
                cpu_rd_i = 1'b0;
            end
        end
        cpu_rd_i = 1'b0;
        chk("timeout arvalid_cycles", n_ar, TO_CYC);
        chk("timeout latency", lat, TO_CYC + 1);
        chk("timeout rdata", rd_out, ERR_D);
        chk("timeout err", {31'b0, err_out}, 32'h1);
        chk("timeout arvalid_dropped", {31'b0, ar_at_done}, 32'h0);

        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;

        model_rdata = 32'h0;
        model_err = 1'b0;
        for (int i = 0; i < 40; i++) begin
            v.wr    = ($urandom_range(0, 1) == 1);
            v.rd    = v.wr ? ($urandom_range(0, 1) == 1) : 1'b1;
            v.addr  = $urandom;
            v.wdata = $urandom;
            v.sel   = 4'($urandom_range(0, 15));
            v.d_a   = $urandom_range(0, v.wr ? 2 : 1);
            v.d_w   = $urandom_range(0, 2);
            v.d_r   = $urandom_range(0, 1);
            v.rdata = $urandom;
            v.resp  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.exp_ax = v.addr & 32'hFFFF_FFFC;
            if (v.wr) v.exp_lat = 3 + ((v.d_a > v.d_w) ? v.d_a : v.d_w) + v.d_r;
            else begin
                v.exp_lat = 3 + v.d_a + v.d_r;
                model_rdata = v.rdata;
            end
            if (v.resp != 2'b00) model_err = 1'b1;
            v.exp_rdata = model_rdata;
            v.exp_err = model_err;
            check_txn($sformatf("rnd%0d", i), v);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
